shift_serial_tx: RTL
====================

Name: shift_serial_tx

Overview:
Parallel-in, serial-out frame transmitter. It is the transmit end of the serial-load path used by the team's universal shift register, which shifts one bit per clock in at its LSB. The block accepts a WIDTH-bit word through a valid/ready handshake. It emits the word on a single line as a framed bit stream: one start bit, WIDTH data bits, then one stop bit. Each bit is held for CLKS_PER_BIT clocks.

Parameters:
WIDTH, 4, data word width in bits (>=1)
CLKS_PER_BIT, 4, clocks each serial bit is held on sdo (>=1)
MSB_FIRST, 1, 1 = send data[WIDTH-1] first; 0 = send data[0] first

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
data  input  WIDTH  parallel word, sampled only on handshake acceptance
load_valid  input  1  sender has a word on data
load_ready  output  1  block can accept a word (high only in IDLE)
sdo  output  1  serial data out, idle level 1
busy  output  1  frame in progress (START, DATA or STOP)
done  output  1  one-cycle pulse after a frame's stop bit completes

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset: while reset==0 at a rising edge, the next state is as follows:
  - state=IDLE, sdo=1, load_ready=1, busy=0, done=0
  - tick and bit counters = 0; shift register = 0
- Reset mid-frame: frame aborted. sdo returns to 1 on that edge and done does not pulse.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Acceptance: a word is accepted on an edge where load_valid && load_ready.
  - data is copied into the internal shift register; the state moves to START.
  - Later changes on data have no effect on the frame in progress.
  - load_valid while busy is ignored; the sender must hold the word until load_ready.
- States:
  - IDLE: sdo=1, load_ready=1. On acceptance go to START.
  - START: sdo=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
  - DATA: sdo = current head bit (MSB or LSB per MSB_FIRST) for CLKS_PER_BIT cycles. Then shift the register one place toward the head and increment the bit counter. After the WIDTH-th bit, go to STOP.
  - STOP: sdo=1 for CLKS_PER_BIT cycles, then go to IDLE and set done=1 for exactly that first IDLE cycle.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. With CLKS_PER_BIT=1, every cycle is a boundary.
- Latency: if acceptance is at edge 0, then:
  - start bit occupies cycles 1..CLKS_PER_BIT
  - total frame is (WIDTH+2)*CLKS_PER_BIT cycles
  - done is high in cycle (WIDTH+2)*CLKS_PER_BIT+1
- Back-to-back: load_ready is high in the done cycle, so a new word can be accepted there. The minimum gap between frames is exactly one idle cycle with sdo=1.
- Widths: bit counter is $clog2(WIDTH+1) bits; tick counter is max(1,$clog2(CLKS_PER_BIT)) bits. No overflow is reachable.
- busy = (state != IDLE); load_ready = (state == IDLE).

Decomposition:
- Shared package shift_serial_pkg holds:
  - state typedef {IDLE, START, DATA, STOP}
  - constants LINE_IDLE=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1
- The package is reused by the matching framed receiver.
- One natural sub-module: bit_tick_gen. It is the CLKS_PER_BIT tick counter with clear input and a one-cycle bit_end output. It has synchronous active-low reset.

Test Plan:
1. Hold reset=0 for 2 cycles with load_valid=1 -> sdo=1, load_ready=1, busy=0, done=0; no word accepted.
2. WIDTH=4, CLKS_PER_BIT=4, MSB_FIRST=1, accept 4'b1011 -> sdo holds 0,1,0,1,1,1 for 4 cycles each (cycles 1..24); done=1 only in cycle 25.
3. MSB_FIRST=0, accept 4'b1011 -> sdo holds 0,1,1,0,1,1 for 4 cycles each; done in cycle 25.
4. Accept 4'b1011, then hold load_valid=1 with data=4'b0110 throughout -> first frame unchanged; load_ready=0 in cycles 1..24. Second word accepted in cycle 25; its start bit begins cycle 26.
5. Drive reset=0 for one cycle during the third data bit -> next cycle sdo=1, busy=0, load_ready=1, no done pulse. Then accept 4'b0001 -> a correct full frame follows.
6. CLKS_PER_BIT=1, WIDTH=4, accept 4'b1100 -> sdo = 0,1,1,0,0,1 in cycles 1..6; done in cycle 7.

Source files
------------

// File: rtl/shift_serial_pkg.sv
// Shared definitions for the framed serial transmitter and its matching receiver:
// frame state encoding, line levels and counter sizing.
package shift_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // A one-clock bit period still needs a one-bit counter to keep the port legal.
    function automatic int tick_width(input int clks);
        return (clks <= 1) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and flags the last clock of each bit.
// Held at zero while clear is asserted so a new frame always starts on a full period.
module bit_tick_gen
    import shift_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int TW = tick_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (clear || (tick_cnt == LAST_TICK)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign bit_end = (tick_cnt == LAST_TICK);

endmodule

// File: rtl/shift_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, WIDTH data bits, stop bit,
// each held CLKS_PER_BIT clocks, with a valid/ready load port and a done pulse.
module shift_serial_tx
    import shift_serial_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [BW-1:0]    bit_cnt, bit_cnt_next;
    logic             done_q, done_next;
    logic             tick_clear;
    logic             bit_end;
    logic             head_bit;

    assign tick_clear = (state == IDLE);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (tick_clear),
        .bit_end(bit_end)
    );

    assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            done_q  <= done_next;
        end
    end

    // The register always shifts toward the head so the outgoing bit sits at a fixed index.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    shreg_next = data;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    bit_cnt_next = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        sdo = LINE_IDLE;
        case (state)
            IDLE:    sdo = LINE_IDLE;
            START:   sdo = START_LEVEL;
            DATA:    sdo = head_bit;
            STOP:    sdo = STOP_LEVEL;
            default: sdo = LINE_IDLE;
        endcase
    end

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = done_q;

endmodule
